wb_commit_ctrl: RTL
===================

Name: wb_commit_ctrl

Overview:
- Writeback-stage commit controller. Sits directly upstream of the CP0 register file.
- Converts the raw per-stage exception/ERET/TLB flags of the instruction in WB into one-hot commit strobes for CP0.
- Drives the pipeline flush, and runs a redirect handshake with the fetch stage (exception vector, EPC, or TLB-op refetch target).

Parameters:
- REFILL_VEC, 32'hbfc00200, TLB refill entry when EXL=0.
- GENERAL_VEC, 32'hbfc00380, all other exceptions, and refill when EXL=1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- ws_valid  in  1  WB holds a valid instruction this cycle; one cycle per instruction.
- ws_pc  in  32  PC of WB instruction.
- ws_bd  in  1  WB instruction is in a delay slot.
- ws_exc  in  15  raw flags, CP0 encoding; bit0 ignored.
- ws_badvaddr  in  32  data-side faulting address.
- ws_eret  in  1  instruction is ERET.
- ws_tlbwi  in  1  instruction is TLBWI.
- ws_tlbr  in  1  instruction is TLBR.
- int_cmt  in  1  pending enabled interrupt, from CP0.
- cp0_status_exl  in  1  Status.EXL.
- cp0_epc  in  32  EPC, from CP0.
- exception_cmt  out  15  one-hot exception commit strobe to CP0.
- eret_cmt  out  1  ERET commit strobe.
- inst_in_slot  out  1  BD of the committing instruction.
- cmt_pc  out  32  PC of the committing instruction.
- cmt_badvaddr  out  32  BadVAddr for CP0.
- tlbr_op  out  1  TLBR commit strobe.
- tlbwi_op  out  1  TLBWI commit strobe (TLB write enable).
- flush  out  1  squash IF/ID/EXE/MEM.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.

Behaviour:
- FSM has two states:
  - IDLE: commits allowed.
  - HOLD: redirect pending; target held in a 32-bit register.
- Reset: state=IDLE, held target=0. While resetn=0 all outputs are 0, regardless of inputs.
- Commit event occurs when state=IDLE and ws_valid=1.
- Commit decode is combinational, zero latency. CP0 samples at the next posedge.
- Priority (highest first), exactly one strobe bit per commit:
  1. int_cmt → exception_cmt[0].
  2. IF faults, in order [8] TLBL-if refill, [9] TLBL-if invalid, [1] ADEL-if.
  3. ID faults, in order [5] RI, [3] syscall, [4] break.
  4. EXE fault [7] Ov.
  5. MEM faults, in order [10], [11], [12], [13], [14], [2], [6].
  6. ERET.
  7. TLBWI / TLBR.
  8. Plain commit.
- Any exception suppresses eret_cmt, tlbwi_op and tlbr_op.
- Outputs driven only during a commit cycle with an exception, ERET or TLB op; otherwise 0:
  - cmt_pc = ws_pc.
  - inst_in_slot = ws_bd.
  - cmt_badvaddr = ws_pc for bits 1, 8, 9; ws_badvaddr otherwise.
- Redirect targets:
  - Refill (bits 8, 10, 12) with EXL=0 → REFILL_VEC.
  - Other exceptions → GENERAL_VEC.
  - ERET → cp0_epc.
  - TLBWI/TLBR → ws_pc+4, mod 2^32 wrap.
  - Plain commit → no redirect, no flush.
- Redirecting commit in IDLE:
  - flush=1 and redirect_valid=1 the same cycle, redirect_pc=target.
  - If redirect_ready=1 that cycle, stay IDLE.
  - Otherwise latch target and go to HOLD.
- HOLD:
  - flush=1 and redirect_valid=1 continuously; redirect_pc = held register.
  - ws_valid ignored; all commit strobes 0.
  - redirect_ready=1 → IDLE next cycle. flush deasserts in that IDLE cycle.
- resetn=0 in HOLD → IDLE; the pending redirect is dropped.
- A commit strobe never lasts more than one cycle per instruction. HOLD guarantees no double commit.

Decomposition:
- Shared package `cpu_exc_pkg`:
  - exception_cmt bit-index constants (EXC_INT=0 … EXC_TLBM=14).
  - Vector constants.
  - FSM state typedef.
- One sub-module, `exc_prio_enc`: purely combinational; 15-bit raw flags + int_cmt → one-hot vector plus is_refill and is_if_fault flags.

Test Plan:
- ws_valid=1, ws_exc[7]=1, pc=0x80001000, bd=1, ready=1 → exception_cmt=0x0080, inst_in_slot=1, redirect_pc=0xbfc00380, one-cycle flush, stays IDLE.
- ws_exc[8]=1 and [5]=1, pc=0x00400000, EXL=0 → exception_cmt=0x0100 only, cmt_badvaddr=0x00400000, redirect_pc=0xbfc00200. Same with EXL=1 → redirect_pc=0xbfc00380.
- int_cmt=1 with ws_tlbwi=1 → exception_cmt=0x0001, tlbwi_op=0.
- TLBWI at pc=0xfffffffc, redirect_ready=0 for 3 cycles → tlbwi_op for one cycle; redirect_pc=0x00000000 held 4 cycles; flush high 4 cycles; second ws_valid during HOLD produces no strobes.
- ERET with cp0_epc=0xbfc00100, ready=1 → eret_cmt=1, redirect_pc=0xbfc00100. ERET plus ws_exc[6] → exception_cmt=0x0040, eret_cmt=0.
- resetn=0 asserted in HOLD → next cycle redirect_valid=0, flush=0, state=IDLE.

Source files
------------

// File: rtl/cpu_exc_pkg.sv
// Shared CP0 exception encoding, exception vectors and commit FSM state type
// used by the writeback commit logic.
package cpu_exc_pkg;

  localparam int EXC_W = 15;

  localparam int EXC_INT       = 0;
  localparam int EXC_ADEL_IF   = 1;
  localparam int EXC_ADEL_D    = 2;
  localparam int EXC_SYS       = 3;
  localparam int EXC_BP        = 4;
  localparam int EXC_RI        = 5;
  localparam int EXC_ADES      = 6;
  localparam int EXC_OV        = 7;
  localparam int EXC_TLBL_IF_R = 8;
  localparam int EXC_TLBL_IF_I = 9;
  localparam int EXC_TLBL_R    = 10;
  localparam int EXC_TLBL_I    = 11;
  localparam int EXC_TLBS_R    = 12;
  localparam int EXC_TLBS_I    = 13;
  localparam int EXC_TLBM      = 14;

  localparam logic [31:0] CPU_REFILL_VEC  = 32'hbfc00200;
  localparam logic [31:0] CPU_GENERAL_VEC = 32'hbfc00380;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } cmt_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: raw per-stage exception flags plus a pending
// interrupt reduce to a single one-hot CP0 exception strobe.
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic [EXC_W-1:1] exc_flags,
  input  logic             int_req,
  output logic [EXC_W-1:0] exc_onehot,
  output logic             is_refill,
  output logic             is_if_fault
);

  // Older pipeline stages win: interrupt, then IF, ID, EXE, MEM faults.
  always_comb begin
    exc_onehot = '0;
    if (int_req)                       exc_onehot[EXC_INT]       = 1'b1;
    else if (exc_flags[EXC_TLBL_IF_R]) exc_onehot[EXC_TLBL_IF_R] = 1'b1;
    else if (exc_flags[EXC_TLBL_IF_I]) exc_onehot[EXC_TLBL_IF_I] = 1'b1;
    else if (exc_flags[EXC_ADEL_IF])   exc_onehot[EXC_ADEL_IF]   = 1'b1;
    else if (exc_flags[EXC_RI])        exc_onehot[EXC_RI]        = 1'b1;
    else if (exc_flags[EXC_SYS])       exc_onehot[EXC_SYS]       = 1'b1;
    else if (exc_flags[EXC_BP])        exc_onehot[EXC_BP]        = 1'b1;
    else if (exc_flags[EXC_OV])        exc_onehot[EXC_OV]        = 1'b1;
    else if (exc_flags[EXC_TLBL_R])    exc_onehot[EXC_TLBL_R]    = 1'b1;
    else if (exc_flags[EXC_TLBL_I])    exc_onehot[EXC_TLBL_I]    = 1'b1;
    else if (exc_flags[EXC_TLBS_R])    exc_onehot[EXC_TLBS_R]    = 1'b1;
    else if (exc_flags[EXC_TLBS_I])    exc_onehot[EXC_TLBS_I]    = 1'b1;
    else if (exc_flags[EXC_TLBM])      exc_onehot[EXC_TLBM]      = 1'b1;
    else if (exc_flags[EXC_ADEL_D])    exc_onehot[EXC_ADEL_D]    = 1'b1;
    else if (exc_flags[EXC_ADES])      exc_onehot[EXC_ADES]      = 1'b1;
  end

  assign is_refill   = exc_onehot[EXC_TLBL_IF_R] | exc_onehot[EXC_TLBL_R] |
                       exc_onehot[EXC_TLBS_R];
  assign is_if_fault = exc_onehot[EXC_TLBL_IF_R] | exc_onehot[EXC_TLBL_IF_I] |
                       exc_onehot[EXC_ADEL_IF];

endmodule

// File: rtl/wb_commit_ctrl.sv
// Writeback commit controller: turns the WB instruction's flags into CP0 commit
// strobes, flushes the pipe and holds a fetch redirect until fetch accepts it.
module wb_commit_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] REFILL_VEC  = CPU_REFILL_VEC,
  parameter logic [31:0] GENERAL_VEC = CPU_GENERAL_VEC
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ws_valid,
  input  logic [31:0]      ws_pc,
  input  logic             ws_bd,
  input  logic [EXC_W-1:0] ws_exc,
  input  logic [31:0]      ws_badvaddr,
  input  logic             ws_eret,
  input  logic             ws_tlbwi,
  input  logic             ws_tlbr,
  input  logic             int_cmt,
  input  logic             cp0_status_exl,
  input  logic [31:0]      cp0_epc,
  output logic [EXC_W-1:0] exception_cmt,
  output logic             eret_cmt,
  output logic             inst_in_slot,
  output logic [31:0]      cmt_pc,
  output logic [31:0]      cmt_badvaddr,
  output logic             tlbr_op,
  output logic             tlbwi_op,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready
);

  cmt_state_e       state_q, state_d;
  logic [31:0]      redir_pc_q, redir_pc_d;

  logic [EXC_W-1:0] exc_onehot;
  logic             is_refill;
  logic             is_if_fault;
  logic             commit;
  logic             has_exc;
  logic             do_eret;
  logic             do_tlbwi;
  logic             do_tlbr;
  logic             need_redirect;
  logic [31:0]      target;

  logic             unused_exc0;
  assign unused_exc0 = ws_exc[0];

  exc_prio_enc u_prio (
    .exc_flags   (ws_exc[EXC_W-1:1]),
    .int_req     (int_cmt),
    .exc_onehot  (exc_onehot),
    .is_refill   (is_refill),
    .is_if_fault (is_if_fault)
  );

  always_comb begin
    commit   = (state_q == ST_IDLE) && ws_valid;
    has_exc  = |exc_onehot;
    do_eret  = ws_eret && !has_exc;
    do_tlbwi = ws_tlbwi && !has_exc && !ws_eret;
    do_tlbr  = ws_tlbr && !has_exc && !ws_eret;
    need_redirect = commit && (has_exc || do_eret || do_tlbwi || do_tlbr);
    if (has_exc) begin
      target = (is_refill && !cp0_status_exl) ? REFILL_VEC : GENERAL_VEC;
    end else if (do_eret) begin
      target = cp0_epc;
    end else begin
      target = ws_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // The target is only captured when fetch cannot take it on the commit cycle.
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (need_redirect && !redirect_ready) begin
          state_d    = ST_HOLD;
          redir_pc_d = target;
        end
      end
      ST_HOLD: begin
        if (redirect_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    exception_cmt  = '0;
    eret_cmt       = 1'b0;
    tlbwi_op       = 1'b0;
    tlbr_op        = 1'b0;
    inst_in_slot   = 1'b0;
    cmt_pc         = '0;
    cmt_badvaddr   = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (resetn) begin
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            exception_cmt = exc_onehot;
            eret_cmt      = do_eret;
            tlbwi_op      = do_tlbwi;
            tlbr_op       = do_tlbr;
          end
          if (need_redirect) begin
            inst_in_slot   = ws_bd;
            cmt_pc         = ws_pc;
            cmt_badvaddr   = is_if_fault ? ws_pc : ws_badvaddr;
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = target;
          end
        end
        ST_HOLD: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = redir_pc_q;
        end
      endcase
    end
  end

endmodule
